// File: rtl/uart_tx_frame_counter.sv
// Bit-position sequencer for the UART TX path: START, DATA, optional PARITY, 1/2 STOP.
// Optional abort input is enabled by defining UART_TX_FRAME_CNT_ABORT_EN.
module uart_tx_frame_counter #(
  parameter  int MAX_DATA_BITS = 9,
  localparam int LEN_W         = $clog2(MAX_DATA_BITS + 1),
  localparam int IDX_W         = $clog2(MAX_DATA_BITS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             tx_en,
  input  logic             start,
  input  logic             ParEN,
  input  logic             StopSel,
  input  logic [LEN_W-1:0] DataLen,
`ifdef UART_TX_FRAME_CNT_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       phase,
  output logic [IDX_W-1:0] bit_idx,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BITS);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < MIN_LEN)
      clamp_len = MIN_LEN;
    else if (len > MAX_LEN)
      clamp_len = MAX_LEN;
    else
      clamp_len = len;
  endfunction

  phase_t             phase_q;
  logic               par_q;
  logic               stop2_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   last_idx;
  logic               tick;

  assign tick     = EN & tx_en;
  // len_q is always >= 5 after latching, so len_q-1 fits the index width
  assign last_idx = IDX_W'(len_q - 1'b1);
  assign phase    = phase_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q <= PH_IDLE;
      bit_idx <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      len_q   <= '0;
    end else begin
      Done <= 1'b0;
      if (phase_q == PH_IDLE) begin
        // leaving IDLE needs no baud tick; config is frozen for the whole frame
        if (start) begin
          par_q   <= ParEN;
          stop2_q <= StopSel;
          len_q   <= clamp_len(DataLen);
          phase_q <= PH_START;
          bit_idx <= '0;
          Busy    <= 1'b1;
        end
      end
`ifdef UART_TX_FRAME_CNT_ABORT_EN
      else if (abort) begin
        phase_q <= PH_IDLE;
        bit_idx <= '0;
        Busy    <= 1'b0;
      end
`endif
      else if (tick) begin
        case (phase_q)
          PH_START: begin
            phase_q <= PH_DATA;
            bit_idx <= '0;
          end
          PH_DATA: begin
            if (bit_idx == last_idx) begin
              bit_idx <= '0;
              phase_q <= par_q ? PH_PARITY : PH_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          PH_PARITY: begin
            phase_q <= PH_STOP;
            bit_idx <= '0;
          end
          PH_STOP: begin
            if (stop2_q && (bit_idx == '0)) begin
              bit_idx <= IDX_W'(1);
            end else begin
              phase_q <= PH_IDLE;
              bit_idx <= '0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end
          end
          default: begin
            phase_q <= PH_IDLE;
            bit_idx <= '0;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_counter.sv
// Directed, table-driven bench for uart_tx_frame_counter (MAX_DATA_BITS = 9).
module tb_uart_tx_frame_counter;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_START = 3'd1;
  localparam logic [2:0] P_DATA  = 3'd2;
  localparam logic [2:0] P_PAR   = 3'd3;
  localparam logic [2:0] P_STOP  = 3'd4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       tx_en = 1'b0;
  logic       start = 1'b0;
  logic       ParEN = 1'b0;
  logic       StopSel = 1'b0;
  logic [3:0] DataLen = 4'd0;
`ifdef UART_TX_FRAME_CNT_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [2:0] phase;
  logic [3:0] bit_idx;
  logic       Busy;
  logic       Done;

  uart_tx_frame_counter #(.MAX_DATA_BITS(9)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .tx_en   (tx_en),
    .start   (start),
    .ParEN   (ParEN),
    .StopSel (StopSel),
    .DataLen (DataLen),
`ifdef UART_TX_FRAME_CNT_ABORT_EN
    .abort   (abort),
`endif
    .phase   (phase),
    .bit_idx (bit_idx),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       st;
    logic       en;
    logic       txe;
    logic       par;
    logic       s2;
    logic [3:0] len;
    logic [2:0] ph;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t       tbl[$];
  logic       c_par;
  logic       c_s2;
  logic [3:0] c_len;
  int         checks = 0;
  int         errors = 0;

  task automatic put(input logic st, input logic en, input logic txe, input logic [2:0] ph,
                     input logic [3:0] idx, input logic busy, input logic done);
    vec_t v;
    v.st = st; v.en = en; v.txe = txe;
    v.par = c_par; v.s2 = c_s2; v.len = c_len;
    v.ph = ph; v.idx = idx; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] ph, input logic [3:0] idx,
                           input logic busy, input logic done);
    chk({tag, ".phase"},   32'(phase),   32'(ph));
    chk({tag, ".bit_idx"}, 32'(bit_idx), 32'(idx));
    chk({tag, ".Busy"},    32'(Busy),    32'(busy));
    chk({tag, ".Done"},    32'(Done),    32'(done));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // 8N1 with a stall, start-while-busy, mid-frame config change and 5 frozen ticks
    c_par = 1'b0; c_s2 = 1'b0; c_len = 4'd8;
    put(1, 0, 1, P_START, 0, 1, 0);
    for (int i = 0; i < 3; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 0, 1, P_DATA, 2, 1, 0);
    c_par = 1'b1; c_len = 4'd5;
    put(1, 1, 1, P_DATA, 3, 1, 0);
    for (int i = 0; i < 5; i++) put(0, 1, 0, P_DATA, 3, 1, 0);
    for (int i = 4; i < 8; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 1, 1, P_STOP, 0, 1, 0);
    put(0, 1, 1, P_IDLE, 0, 0, 1);
    put(0, 1, 1, P_IDLE, 0, 0, 0);
    // 8E2: 12 ticks
    c_par = 1'b1; c_s2 = 1'b1; c_len = 4'd8;
    put(1, 0, 1, P_START, 0, 1, 0);
    for (int i = 0; i < 8; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 1, 1, P_PAR, 0, 1, 0);
    put(0, 1, 1, P_STOP, 0, 1, 0);
    put(0, 1, 1, P_STOP, 1, 1, 0);
    put(0, 1, 1, P_IDLE, 0, 0, 1);
    put(0, 0, 1, P_IDLE, 0, 0, 0);
    // DataLen=3 clamps to 5; start with a coincident tick only reaches START
    c_par = 1'b0; c_s2 = 1'b0; c_len = 4'd3;
    put(1, 1, 1, P_START, 0, 1, 0);
    put(0, 1, 1, P_DATA, 0, 1, 0);
    c_len = 4'd15;
    for (int i = 1; i < 5; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 1, 1, P_STOP, 0, 1, 0);
    put(0, 1, 1, P_IDLE, 0, 0, 1);
    put(0, 0, 1, P_IDLE, 0, 0, 0);
    // DataLen=15 clamps to 9, then start held across Done gives a back-to-back 5-bit frame
    c_len = 4'd15;
    put(1, 0, 1, P_START, 0, 1, 0);
    put(0, 1, 1, P_DATA, 0, 1, 0);
    c_len = 4'd3;
    for (int i = 1; i < 9; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 1, 1, P_STOP, 0, 1, 0);
    put(1, 1, 1, P_IDLE, 0, 0, 1);
    put(1, 0, 1, P_START, 0, 1, 0);
    for (int i = 0; i < 5; i++) put(0, 1, 1, P_DATA, 4'(i), 1, 0);
    put(0, 1, 1, P_STOP, 0, 1, 0);
    put(0, 1, 1, P_IDLE, 0, 0, 1);
    put(0, 0, 1, P_IDLE, 0, 0, 0);

    // reset state
    RST = 1'b0;
    step();
    step();
    check_out("reset", P_IDLE, 0, 0, 0);
    RST = 1'b1;
    step();
    check_out("post_reset", P_IDLE, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start   = tbl[i].st;
      EN      = tbl[i].en;
      tx_en   = tbl[i].txe;
      ParEN   = tbl[i].par;
      StopSel = tbl[i].s2;
      DataLen = tbl[i].len;
      step();
      check_out($sformatf("vec%0d", i), tbl[i].ph, tbl[i].idx, tbl[i].busy, tbl[i].done);
    end
    start = 1'b0; EN = 1'b0; tx_en = 1'b1;

    // reset asserted during the 4th tick of an 8N1 frame
    ParEN = 1'b0; StopSel = 1'b0; DataLen = 4'd8;
    start = 1'b1;
    step();
    check_out("rst_start", P_START, 0, 1, 0);
    start = 1'b0; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("rst_d%0d", i), P_DATA, 4'(i), 1, 0);
    end
    #3 RST = 1'b0;
    #1 check_out("rst_async", P_IDLE, 0, 0, 0);
    step();
    check_out("rst_hold", P_IDLE, 0, 0, 0);
    RST = 1'b1;
    step();
    check_out("rst_release", P_IDLE, 0, 0, 0);
    step();
    check_out("rst_nodone", P_IDLE, 0, 0, 0);
    EN = 1'b0;

`ifdef UART_TX_FRAME_CNT_ABORT_EN
    // 5E1 frame aborted in PARITY with a coincident tick
    ParEN = 1'b1; StopSel = 1'b0; DataLen = 4'd5;
    start = 1'b1;
    step();
    check_out("ab_start", P_START, 0, 1, 0);
    start = 1'b0; EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("ab_d%0d", i), P_DATA, 4'(i), 1, 0);
    end
    step();
    check_out("ab_par", P_PAR, 0, 1, 0);
    abort = 1'b1;
    step();
    check_out("ab_abort", P_IDLE, 0, 0, 0);
    abort = 1'b0; EN = 1'b0;
    step();
    check_out("ab_idle", P_IDLE, 0, 0, 0);
    abort = 1'b1; start = 1'b1;
    step();
    check_out("ab_startwins", P_START, 0, 1, 0);
    abort = 1'b0; start = 1'b0; EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("ab2_d%0d", i), P_DATA, 4'(i), 1, 0);
    end
    step();
    check_out("ab2_par", P_PAR, 0, 1, 0);
    step();
    check_out("ab2_stop", P_STOP, 0, 1, 0);
    step();
    check_out("ab2_done", P_IDLE, 0, 0, 1);
    EN = 1'b0;
    step();
    check_out("ab2_idle", P_IDLE, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
